// File: rtl/pe_core_kxk.sv
// pe_core_kxk: parametrised KxK convolution processing element.
// Takes one K-pixel column per cycle into a sliding KxK window. Weights and
// bias are double-buffered: a shadow set loads while the active set computes.
// Each complete window produces one pipelined dot product plus bias or
// residual, with optional ReLU. Result appears four edges after acceptance.
module pe_core_kxk #(
    parameter int FEATURE_WIDTH    = 16,
    parameter int WEIGHT_WIDTH     = 16,
    parameter int KERNEL_SIZE      = 3,
    parameter int BIAS_WIDTH       = FEATURE_WIDTH + WEIGHT_WIDTH,
    parameter int MAC_OUTPUT_WIDTH = FEATURE_WIDTH + WEIGHT_WIDTH + 8
) (
    input  logic                                  DSP_clk,
    input  logic                                  rst,
    input  logic [WEIGHT_WIDTH-1:0]               weight,
    input  logic                                  weight_valid,
    input  logic [BIAS_WIDTH-1:0]                 bias,
    input  logic                                  bias_valid,
    input  logic                                  weight_swap,
    output logic                                  weight_loaded,
    input  logic [KERNEL_SIZE*FEATURE_WIDTH-1:0]  feature_in,
    input  logic                                  feature_valid,
    input  logic                                  line_start,
    input  logic [MAC_OUTPUT_WIDTH-1:0]           adder_feature,
    input  logic                                  bias_or_adder_feature,
    input  logic                                  relu_en,
    output logic [MAC_OUTPUT_WIDTH-1:0]           feature_out,
    output logic                                  out_valid
);

    localparam int K   = KERNEL_SIZE;
    localparam int KK  = K * K;
    localparam int FW  = FEATURE_WIDTH;
    localparam int WW  = WEIGHT_WIDTH;
    localparam int MW  = MAC_OUTPUT_WIDTH;
    localparam int PW  = FEATURE_WIDTH + WEIGHT_WIDTH;
    localparam int WCW = $clog2(KK + 1);
    localparam int FCW = $clog2(K + 1);

    // Weight/bias banks; index i = r*K + c, column 0 is the oldest column.
    logic signed [WW-1:0]         sw [KK];
    logic signed [WW-1:0]         aw [KK];
    logic signed [BIAS_WIDTH-1:0] sb;
    logic signed [BIAS_WIDTH-1:0] ab;
    logic [WCW-1:0]               wcnt;
    logic                         swap_ok;

    // Sliding window and fill tracking.
    logic signed [FW-1:0] win      [K][K];
    logic signed [FW-1:0] win_next [K][K];
    logic [FCW-1:0]       fcnt;
    logic [FCW-1:0]       fcnt_next;
    logic                 completing;
    logic signed [MW-1:0] addend_next;

    // Pipeline: products -> row sums -> total -> total+addend -> output.
    logic signed [PW-1:0] p1 [KK];
    logic signed [MW-1:0] rs2 [K];
    logic signed [MW-1:0] rs_next [K];
    logic signed [MW-1:0] tot3;
    logic signed [MW-1:0] tot_next;
    logic signed [MW-1:0] sum4;
    logic signed [MW-1:0] add1, add2, add3;
    logic                 relu1, relu2, relu3, relu4;
    logic                 v1, v2, v3, v4;

    assign swap_ok       = weight_swap && (wcnt == WCW'(KK));
    assign weight_loaded = (wcnt == WCW'(KK));
    assign completing    = feature_valid && (fcnt_next == FCW'(K));
    assign addend_next   = bias_or_adder_feature ? MW'(ab) : $signed(adder_feature);

    // Shadow load, swap into the active set, and load-count tracking.
    // NOTE: the swap copies sw/sb with <=, so the active set takes the
    // pre-edge shadow even when a write or bias_valid lands on the same edge.
    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KK; i++) begin
                sw[i] <= '0;
                aw[i] <= '0;
            end
            sb   <= '0;
            ab   <= '0;
            wcnt <= '0;
        end else begin
            if (weight_valid) begin
                for (int i = 0; i < KK - 1; i++) sw[i] <= sw[i+1];
                sw[KK-1] <= $signed(weight);
            end
            if (bias_valid) sb <= $signed(bias);
            if (swap_ok) begin
                aw   <= sw;
                ab   <= sb;
                wcnt <= weight_valid ? WCW'(1) : '0;
            end else if (weight_valid && (wcnt != WCW'(KK))) begin
                wcnt <= wcnt + WCW'(1);
            end
        end
    end

    // Next window contents and fill count for the column being presented.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        win_next  = win;
        fcnt_next = fcnt;
        if (feature_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win_next[r][c] = win[r][c+1];
                win_next[r][K-1] = $signed(feature_in[r*FW +: FW]);
            end
        end
        if (line_start)
            fcnt_next = feature_valid ? FCW'(1) : '0;
        else if (feature_valid && (fcnt != FCW'(K)))
            fcnt_next = fcnt + FCW'(1);
    end

    // Window shift registers and fill counter.
    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) win[r][c] <= '0;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt_next;
            if (feature_valid) win <= win_next;
        end
    end

    // Row sums of the product stage and the total of the row sums.
    always_comb begin
        tot_next = '0;
        for (int r = 0; r < K; r++) begin
            rs_next[r] = '0;
            for (int c = 0; c < K; c++) rs_next[r] = rs_next[r] + MW'(p1[r*K + c]);
        end
        for (int r = 0; r < K; r++) tot_next = tot_next + rs2[r];
    end

    // Datapath registers; only the valid bits below qualify them.
    // NOTE: these wide registers are not reset, since nothing downstream
    // looks at them unless the matching valid bit is set.
    always_ff @(posedge DSP_clk) begin
        if (completing) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    p1[r*K + c] <= PW'(aw[r*K + c]) * PW'(win_next[r][c]);
            add1  <= addend_next;
            relu1 <= relu_en;
        end
        rs2   <= rs_next;
        add2  <= add1;
        relu2 <= relu1;
        tot3  <= tot_next;
        add3  <= add2;
        relu3 <= relu2;
        sum4  <= tot3 + add3;
        relu4 <= relu3;
    end

    // Valid pipeline and output register with ReLU; output holds between results.
    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            v4          <= 1'b0;
            out_valid   <= 1'b0;
            feature_out <= '0;
        end else begin
            v1        <= completing;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            if (v4) feature_out <= (relu4 && sum4[MW-1]) ? '0 : sum4;
        end
    end

endmodule

// File: tb/tb_pe_core_kxk.sv
// tb_pe_core_kxk: scoreboard bench for pe_core_kxk. Main instance K=3, plus
// K=5 and K=1 instances for the full-scale extreme-value products.
module tb_pe_core_kxk;

    localparam int FW = 16;
    localparam int WW = 16;
    localparam int BW = 32;
    localparam int MW = 40;

    logic          DSP_clk = 1'b0;
    logic          rst;
    logic [WW-1:0] weight;
    logic          weight_valid, bias_valid, weight_swap;
    logic [BW-1:0] bias;
    logic          feature_valid, fv_x, line_start;
    logic [MW-1:0] adder_feature;
    logic          bof, relu_en;
    logic [3*FW-1:0] fin3;
    logic [5*FW-1:0] fin5;
    logic [FW-1:0]   fin1;
    logic [MW-1:0] fo3, fo5, fo1;
    logic          ov3, ov5, ov1, wl3, wl5, wl1;

    always #5 DSP_clk = ~DSP_clk;

    pe_core_kxk #(.KERNEL_SIZE(3)) u3 (
        .DSP_clk(DSP_clk), .rst(rst), .weight(weight), .weight_valid(weight_valid),
        .bias(bias), .bias_valid(bias_valid), .weight_swap(weight_swap),
        .weight_loaded(wl3), .feature_in(fin3), .feature_valid(feature_valid),
        .line_start(line_start), .adder_feature(adder_feature),
        .bias_or_adder_feature(bof), .relu_en(relu_en),
        .feature_out(fo3), .out_valid(ov3));

    pe_core_kxk #(.KERNEL_SIZE(5)) u5 (
        .DSP_clk(DSP_clk), .rst(rst), .weight(weight), .weight_valid(weight_valid),
        .bias(bias), .bias_valid(bias_valid), .weight_swap(weight_swap),
        .weight_loaded(wl5), .feature_in(fin5), .feature_valid(fv_x),
        .line_start(line_start), .adder_feature(adder_feature),
        .bias_or_adder_feature(bof), .relu_en(relu_en),
        .feature_out(fo5), .out_valid(ov5));

    pe_core_kxk #(.KERNEL_SIZE(1)) u1 (
        .DSP_clk(DSP_clk), .rst(rst), .weight(weight), .weight_valid(weight_valid),
        .bias(bias), .bias_valid(bias_valid), .weight_swap(weight_swap),
        .weight_loaded(wl1), .feature_in(fin1), .feature_valid(fv_x),
        .line_start(line_start), .adder_feature(adder_feature),
        .bias_or_adder_feature(bof), .relu_en(relu_en),
        .feature_out(fo1), .out_valid(ov1));

    typedef struct {
        logic [MW-1:0] val;
        int            due;
    } exp_t;

    exp_t q3[$];
    exp_t q5[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_cnt = 0;

    always @(posedge DSP_clk) cyc_cnt++;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Result due at the negedge after acceptance edge + 4.
    function automatic exp_t mk(input longint v);
        exp_t e;
        e.val = MW'(v);
        e.due = cyc_cnt + 5;
        return e;
    endfunction

    // Monitors: pop and compare whenever a DUT presents a result.
    always @(negedge DSP_clk) begin
        if (ov3) begin
            if (q3.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL k3_unexpected: got out_valid with %0d, expected none", $signed(fo3));
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("k3_value", $signed(fo3), $signed(e.val));
                check("k3_latency", cyc_cnt, e.due);
            end
        end
    end

    always @(negedge DSP_clk) begin
        if (ov5) begin
            if (q5.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL k5_unexpected: got out_valid with %0d, expected none", $signed(fo5));
            end else begin
                exp_t e;
                e = q5.pop_front();
                check("k5_value", $signed(fo5), $signed(e.val));
                check("k5_latency", cyc_cnt, e.due);
            end
        end
    end

    always @(negedge DSP_clk) begin
        if (ov1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL k1_unexpected: got out_valid with %0d, expected none", $signed(fo1));
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("k1_value", $signed(fo1), $signed(e.val));
                check("k1_latency", cyc_cnt, e.due);
            end
        end
    end

    task automatic cyc();
        @(negedge DSP_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic load_w(input longint w);
        weight       = WW'(w);
        weight_valid = 1'b1;
        cyc();
        weight_valid = 1'b0;
    endtask

    task automatic set_bias(input longint b);
        bias       = BW'(b);
        bias_valid = 1'b1;
        cyc();
        bias_valid = 1'b0;
    endtask

    task automatic swap();
        weight_swap = 1'b1;
        cyc();
        weight_swap = 1'b0;
    endtask

    // One K=3 column; lane r is kernel row r. Pushes an expectation if has_exp.
    task automatic col3(input longint a0, input longint a1, input longint a2,
                        input logic ls, input logic has_exp, input longint e);
        fin3          = {FW'(a2), FW'(a1), FW'(a0)};
        feature_valid = 1'b1;
        line_start    = ls;
        if (has_exp) q3.push_back(mk(e));
        cyc();
        feature_valid = 1'b0;
        line_start    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        weight = '0; weight_valid = 1'b0; bias = '0; bias_valid = 1'b0;
        weight_swap = 1'b0; feature_valid = 1'b0; fv_x = 1'b0; line_start = 1'b0;
        adder_feature = '0; bof = 1'b1; relu_en = 1'b0;
        fin3 = '0; fin5 = '0; fin1 = '0;
        idle(2);
        rst = 1'b0;
        cyc();
        check("rst_out_valid", ov3, 0);
        check("rst_feature_out", fo3, 0);
        check("rst_weight_loaded", wl3, 0);

        // Basic convolution: weights 1..9, bias 0, all-ones window -> 45.
        for (int i = 1; i <= 8; i++) load_w(i);
        check("t1_loaded_after_8", wl3, 0);
        load_w(9);
        check("t1_loaded_after_9", wl3, 1);
        set_bias(0);
        swap();
        check("t1_loaded_after_swap", wl3, 0);
        col3(1, 1, 1, 1'b1, 1'b0, 0);
        col3(1, 1, 1, 1'b0, 1'b0, 0);
        col3(1, 1, 1, 1'b0, 1'b1, 45);
        col3(1, 1, 1, 1'b0, 1'b1, 45);
        idle(8);
        check("t1_idle_valid", ov3, 0);
        check("t1_hold_value", $signed(fo3), 45);

        // Bias and ReLU: bias -50 -> -5, ReLU -> 0, residual 100 -> 145.
        for (int i = 1; i <= 9; i++) load_w(i);
        set_bias(-50);
        swap();
        col3(1, 1, 1, 1'b0, 1'b1, -5);
        relu_en = 1'b1;
        col3(1, 1, 1, 1'b0, 1'b1, 0);
        relu_en = 1'b0;
        bof = 1'b0;
        adder_feature = MW'(100);
        col3(1, 1, 1, 1'b0, 1'b1, 145);
        adder_feature = '0;
        idle(6);

        // Double buffering: load all-2 weights while streaming, swap mid-stream.
        for (int i = 0; i < 12; i++) begin
            weight       = WW'(2);
            weight_valid = (i < 9);
            weight_swap  = (i == 9);
            col3(1, 1, 1, 1'b0, 1'b1, (i <= 9) ? 45 : 18);
        end
        weight_valid = 1'b0;
        weight_swap  = 1'b0;
        check("t3_loaded_after_swap", wl3, 0);
        for (int i = 1; i <= 8; i++) load_w(i);
        check("t3_loaded_after_8", wl3, 0);
        swap();
        check("t3_short_swap_loaded", wl3, 0);
        col3(1, 1, 1, 1'b0, 1'b1, 18);
        load_w(9);
        check("t3_loaded_after_9th", wl3, 1);
        swap();
        col3(1, 1, 1, 1'b0, 1'b1, 45);
        idle(6);

        // Row restart: lanes j, j+100, j+200; window (a,b,c) -> 12a+15b+18c+6300.
        for (int j = 1; j <= 7; j++) begin
            case (j)
                3:       col3(j, j + 100, j + 200, 1'b0, 1'b1, 6396);
                4:       col3(j, j + 100, j + 200, 1'b0, 1'b1, 6441);
                7:       col3(j, j + 100, j + 200, 1'b0, 1'b1, 6576);
                default: col3(j, j + 100, j + 200, (j == 1 || j == 5), 1'b0, 0);
            endcase
        end
        idle(6);

        // Reset with three results in flight: none may emerge.
        bof = 1'b1;
        col3(1, 1, 1, 1'b0, 1'b0, 0);
        col3(1, 1, 1, 1'b0, 1'b0, 0);
        col3(1, 1, 1, 1'b0, 1'b0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t5_out_valid", ov3, 0);
        check("t5_feature_out", fo3, 0);
        check("t5_weight_loaded", wl3, 0);
        idle(8);
        col3(3, 5, 7, 1'b1, 1'b0, 0);
        col3(3, 5, 7, 1'b0, 1'b0, 0);
        col3(3, 5, 7, 1'b0, 1'b1, 0);
        idle(6);

        // Extremes: all features and weights -32768, bias 0 -> K*K * 2^30.
        for (int i = 0; i < 25; i++) load_w(-32768);
        check("t6_loaded_k3", wl3, 1);
        check("t6_loaded_k5", wl5, 1);
        check("t6_loaded_k1", wl1, 1);
        swap();
        fin3 = {3{16'h8000}};
        fin5 = {5{16'h8000}};
        fin1 = 16'h8000;
        for (int j = 0; j < 5; j++) begin
            feature_valid = 1'b1;
            fv_x          = 1'b1;
            line_start    = (j == 0);
            q1.push_back(mk(64'sd1073741824));
            if (j >= 2) q3.push_back(mk(64'sd9663676416));
            if (j == 4) q5.push_back(mk(64'sd26843545600));
            cyc();
        end
        feature_valid = 1'b0;
        fv_x          = 1'b0;
        line_start    = 1'b0;
        idle(8);

        check("k3_drain", q3.size(), 0);
        check("k5_drain", q5.size(), 0);
        check("k1_drain", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
